psum_ctrl: RTL and testbench

//  Sequences the H x W partial-sum accumulator for one output tile.

---
 rtl/psum_ctrl_if.sv | 45 ++++
 rtl/psum_ctrl.sv | 161 ++++++++++++++++
 tb/tb_psum_ctrl.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/psum_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : psum_ctrl_if                                                    |
// | Purpose  : Control, product-stream, accumulator and drain-stream signals  |
// |            of the partial-sum controller. master = controller side.       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface psum_ctrl_if #(
  parameter int DATA_WIDTH = 24,
  parameter int PASS_W     = 8
);
  logic                  start;
  logic [PASS_W-1:0]     num_pass;
  logic                  busy;
  logic                  done;

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;

  logic                  ps_ce;
  logic                  ps_clear;
  logic [7:0]            ps_addr;
  logic [DATA_WIDTH-1:0] ps_in_data;
  logic                  ps_in_valid;
  logic [DATA_WIDTH-1:0] ps_rd_data;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;

  modport master (
    input  start, num_pass, in_valid, in_data, ps_rd_data, out_ready,
    output busy, done, in_ready, ps_ce, ps_clear, ps_addr, ps_in_data,
           ps_in_valid, out_valid, out_data, out_last
  );

  modport slave (
    output start, num_pass, in_valid, in_data, ps_rd_data, out_ready,
    input  busy, done, in_ready, ps_ce, ps_clear, ps_addr, ps_in_data,
           ps_in_valid, out_valid, out_data, out_last
  );
endinterface
`default_nettype wire

// File: rtl/psum_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : psum_ctrl                                                       |
// | Purpose  : Clears an H x W partial-sum array, streams num_pass sweeps of   |
// |            products into it, then drains the tile in raster order.        |
// | Options  : PSUM_RELU_EN - clamp negative drained values to zero.          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module psum_ctrl #(
  parameter int DATA_WIDTH = 24,
  parameter int H          = 12,
  parameter int W          = 11,
  parameter int PASS_W     = 8
) (
  input  wire logic   clk,
  input  wire logic   rst,
  psum_ctrl_if.master bus
);

  localparam int                c_N        = H * W;
  localparam logic [7:0]        c_LAST     = 8'(c_N - 1);
  localparam logic [PASS_W-1:0] c_ONE_PASS = PASS_W'(1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_CLEAR      = 3'd1,
    S_ACCUM      = 3'd2,
    S_DRAIN_RD   = 3'd3,
    S_DRAIN_CAP  = 3'd4,
    S_DRAIN_HOLD = 3'd5,
    S_DONE       = 3'd6
  } state_t;

  state_t                r_state;
  logic [PASS_W-1:0]     r_num_pass;
  logic [PASS_W-1:0]     r_pass;
  logic [7:0]            r_addr;
  logic [7:0]            r_daddr;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_in_ready;
  logic                  r_clear;
  logic                  r_out_valid;
  logic                  r_out_last;
  logic [DATA_WIDTH-1:0] r_out_data;

  logic                  w_accum;
  logic                  w_drain;
  logic                  w_in_hs;
  logic                  w_out_hs;
  logic [DATA_WIDTH-1:0] w_drain_val;

  assign w_accum  = (r_state == S_ACCUM);
  assign w_drain  = (r_state == S_DRAIN_RD) || (r_state == S_DRAIN_CAP) ||
                    (r_state == S_DRAIN_HOLD);
  assign w_in_hs  = w_accum && r_in_ready && bus.in_valid;
  assign w_out_hs = r_out_valid && bus.out_ready;

`ifdef PSUM_RELU_EN
  assign w_drain_val = bus.ps_rd_data[DATA_WIDTH-1] ? '0 : bus.ps_rd_data;
`else
  assign w_drain_val = bus.ps_rd_data;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_num_pass  <= '0;
      r_pass      <= '0;
      r_addr      <= '0;
      r_daddr     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_clear     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_num_pass <= (bus.num_pass == '0) ? c_ONE_PASS : bus.num_pass;
            r_busy     <= 1'b1;
            r_clear    <= 1'b1;
            r_state    <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          r_clear    <= 1'b0;
          r_addr     <= '0;
          r_pass     <= '0;
          r_in_ready <= 1'b1;
          r_state    <= S_ACCUM;
        end
        S_ACCUM: begin
          if (w_in_hs) begin
            if (r_addr == c_LAST) begin
              r_addr <= '0;
              r_pass <= r_pass + c_ONE_PASS;
              // Final product of the final sweep: stop accepting and drain.
              if (r_pass == r_num_pass - c_ONE_PASS) begin
                r_in_ready <= 1'b0;
                r_daddr    <= '0;
                r_state    <= S_DRAIN_RD;
              end
            end else begin
              r_addr <= r_addr + 8'd1;
            end
          end
        end
        S_DRAIN_RD: begin
          r_state <= S_DRAIN_CAP;
        end
        S_DRAIN_CAP: begin
          r_out_data  <= w_drain_val;
          r_out_valid <= 1'b1;
          r_out_last  <= (r_daddr == c_LAST);
          r_state     <= S_DRAIN_HOLD;
        end
        S_DRAIN_HOLD: begin
          if (w_out_hs) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            if (r_out_last) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_daddr <= r_daddr + 8'd1;
              r_state <= S_DRAIN_RD;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Product path is forwarded combinationally so accumulation has zero latency.
  assign bus.ps_in_valid = w_accum && bus.in_valid;
  assign bus.ps_in_data  = w_accum ? bus.in_data : '0;
  assign bus.ps_addr     = w_accum ? r_addr : (w_drain ? r_daddr : 8'd0);

  assign bus.busy        = r_busy;
  assign bus.ps_ce       = r_busy;
  assign bus.done        = r_done;
  assign bus.in_ready    = r_in_ready;
  assign bus.ps_clear    = r_clear;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_last    = r_out_last;
  assign bus.out_data    = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_psum_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_psum_ctrl                                                    |
// | Purpose  : Randomized scoreboard bench for psum_ctrl with an accumulator  |
// |            array model and a per-element sum reference.                   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_psum_ctrl;
  localparam int DW = 24;
  localparam int H  = 12;
  localparam int W  = 11;
  localparam int PW = 8;
  localparam int N  = H * W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  psum_ctrl_if #(.DATA_WIDTH(DW), .PASS_W(PW)) bus ();

  psum_ctrl #(.DATA_WIDTH(DW), .H(H), .W(W), .PASS_W(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Accumulator array model: commands captured mid-cycle, applied on the edge.
  logic [DW-1:0] acc [N];
  logic          m_clr  = 1'b0;
  logic          m_we   = 1'b0;
  logic [7:0]    m_addr = 8'd0;
  logic [DW-1:0] m_data = '0;

  always @(negedge clk) begin
    m_clr  = bus.ps_clear;
    m_we   = bus.ps_ce & bus.ps_in_valid;
    m_addr = bus.ps_addr;
    m_data = bus.ps_in_data;
  end

  always @(posedge clk) begin
    if (m_clr) begin
      for (int i = 0; i < N; i++) acc[i] <= '0;
    end else if (m_we && int'(m_addr) < N) begin
      acc[m_addr] <= acc[m_addr] + m_data;
    end
    bus.ps_rd_data <= (int'(m_addr) < N) ? acc[m_addr] : '0;
  end

  // Scoreboard monitor
  logic [DW-1:0] expq [$];
  bit            lastq[$];
  int            strobes = 0;
  int            clears  = 0;
  int            dones   = 0;
  int            pops    = 0;
  bit            hold_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.ps_in_valid) begin
        check("strobe_addr", 32'(bus.ps_addr), 32'(strobes % N));
        strobes++;
      end
      if (bus.ps_clear) begin
        clears++;
        check("clear_without_strobe", 32'(bus.ps_in_valid), 32'd0);
      end
      if (bus.done) dones++;
      if (hold_prev) check("out_valid_held", 32'(bus.out_valid), 32'd1);
      if (bus.out_valid) begin
        if (expq.size() == 0) begin
          check("unexpected_out", 32'(bus.out_valid), 32'd0);
        end else begin
          check("out_data", 32'(bus.out_data), 32'(expq[0]));
          check("out_last", 32'(bus.out_last), 32'(lastq[0]));
          if (bus.out_ready) begin
            void'(expq.pop_front());
            void'(lastq.pop_front());
            pops++;
          end
        end
      end
      hold_prev = bus.out_valid & ~bus.out_ready;
    end else begin
      hold_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic recover();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    expq.delete();
    lastq.delete();
  endtask

  task automatic send(input logic [DW-1:0] d, input bit rnd, output bit ok);
    int to;
    if (rnd && $urandom_range(0, 3) == 0) begin
      bus.in_valid = 1'b0;
      repeat ($urandom_range(1, 2)) tick();
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    to = 0;
    do begin
      @(negedge clk);
      ok = bus.in_ready;
      to++;
    end while (!ok && to < 50);
    @(posedge clk);
    #1;
  endtask

  task automatic run_tile(input int np, input int mode, input int stall_idx,
                          input bit drain_start, input bit rnd);
    int            eff;
    int            to;
    int            stall_cnt;
    bit            ok;
    logic [DW-1:0] d;
    logic [DW-1:0] v;
    logic [DW-1:0] sum [N];
    logic [DW-1:0] prods [$];

    eff = (np == 0) ? 1 : np;
    for (int i = 0; i < N; i++) sum[i] = '0;
    for (int k = 0; k < N * eff; k++) begin
      case (mode)
        0:       d = DW'(k % N + 1);
        1:       d = DW'(1);
        2:       d = 24'hFFFFFB;
        default: d = DW'($urandom);
      endcase
      prods.push_back(d);
      sum[k % N] = sum[k % N] + d;
    end
    for (int i = 0; i < N; i++) begin
      v = sum[i];
`ifdef PSUM_RELU_EN
      if (v[DW-1]) v = '0;
`endif
      expq.push_back(v);
      lastq.push_back(i == N - 1);
    end

    strobes = 0; clears = 0; dones = 0; pops = 0;
    bus.out_ready = 1'b1;
    bus.num_pass  = PW'(np);
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
    bus.num_pass  = PW'($urandom);

    ok = 1'b1;
    foreach (prods[k]) begin
      send(prods[k], rnd, ok);
      if (!ok) begin
        check("in_ready_timeout", 32'(ok), 32'd1);
        break;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    to = 0;
    stall_cnt = 0;
    while (dones == 0 && to < 4000) begin
      if (stall_idx >= 0 && pops == stall_idx && bus.out_valid && stall_cnt < 10) begin
        bus.out_ready = 1'b0;
        stall_cnt++;
      end else begin
        bus.out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      bus.start = drain_start && (pops == 3);
      tick();
      to++;
    end
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;

    check("done_seen", 32'(dones), 32'd1);
    check("strobe_count", 32'(strobes), 32'(N * eff));
    check("clear_count", 32'(clears), 32'd1);
    check("drain_count", 32'(pops), 32'(N));
    if (stall_idx >= 0) check("stall_cycles", 32'(stall_cnt), 32'd10);
    repeat (5) tick();
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("done_once", 32'(dones), 32'd1);
    if (dones == 0) recover();
    expq.delete();
    lastq.delete();
  endtask

  task automatic reset_abort_test();
    bit ok;
    strobes = 0;
    bus.num_pass = PW'(1);
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
    for (int k = 0; k < 50; k++) begin
      send(DW'(7), 1'b0, ok);
      if (!ok) begin
        check("abort_in_ready_timeout", 32'(ok), 32'd1);
        break;
      end
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_in_ready", 32'(bus.in_ready), 32'd0);
    check("abort_ps_in_valid", 32'(bus.ps_in_valid), 32'd0);
    check("abort_ps_clear", 32'(bus.ps_clear), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    tick();
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.num_pass  = '0;
    bus.in_valid  = 1'b1;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_ps_ce", 32'(bus.ps_ce), 32'd0);
    check("rst_ps_clear", 32'(bus.ps_clear), 32'd0);
    check("rst_ps_addr", 32'(bus.ps_addr), 32'd0);
    check("rst_ps_in_valid", 32'(bus.ps_in_valid), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_last", 32'(bus.out_last), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    tick();

    run_tile(1, 0, -1, 1'b0, 1'b0);   // ramp data, one sweep
    run_tile(3, 1, -1, 1'b0, 1'b0);   // three sweeps of ones
    run_tile(0, 0, -1, 1'b0, 1'b0);   // zero passes behaves as one
    run_tile(1, 3,  5, 1'b0, 1'b0);   // downstream stall on element 5
    reset_abort_test();
    run_tile(2, 3, -1, 1'b0, 1'b1);   // stale array must be cleared
    run_tile(1, 2, -1, 1'b0, 1'b0);   // negative products
    run_tile(1, 3, -1, 1'b1, 1'b0);   // start during drain is ignored
    for (int t = 0; t < 3; t++) begin
      run_tile(int'($urandom_range(0, 3)), 3, -1, 1'b0, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
